// File: rtl/shifter_arbiter.sv
// shifter_arbiter: round-robin sharing of one full_barrel_shifter between two requesters.
// Define SHIFTER_ARB_ROTATE_EN to enable two-pass rotates (ROT2 state).

module full_barrel_shifter #(
   parameter int XLEN = 32,
   parameter int YLEN = 1
) (
   input  logic [XLEN-1:0][YLEN-1:0] data,
   input  logic [$clog2(XLEN)-1:0]   shamt,
   input  logic                      left_or_right_shift,
   input  logic                      arithmetic_right_shift,
   output logic [XLEN-1:0][YLEN-1:0] result
);
   localparam int W = XLEN * YLEN;

   logic [W-1:0] flat_s;
   logic [31:0]  bit_amt_s;
   logic         fill_s;

   assign flat_s    = data;
   assign bit_amt_s = 32'(shamt) * 32'(YLEN);
   assign fill_s    = arithmetic_right_shift & flat_s[W-1];

   // Sign fill is done by shifting the complement so vacated bits come back as ones.
   always_comb begin
      if (!left_or_right_shift) begin
         result = flat_s << bit_amt_s;
      end else if (fill_s) begin
         result = ~((~flat_s) >> bit_amt_s);
      end else begin
         result = flat_s >> bit_amt_s;
      end
   end
endmodule

module shifter_arbiter #(
   parameter int XLEN = 32,
   parameter int YLEN = 1
) (
   input  logic                                 clock,
   input  logic                                 reset,
   input  logic [1:0]                           req_valid,
   output logic [1:0]                           req_ready,
   input  logic [1:0][XLEN-1:0][YLEN-1:0]       req_data,
   input  logic [1:0][$clog2(XLEN)-1:0]         req_shamt,
   input  logic [1:0]                           req_left_or_right,
   input  logic [1:0]                           req_arith,
   input  logic [1:0]                           req_rotate,
   output logic                                 resp_valid,
   input  logic                                 resp_ready,
   output logic [XLEN-1:0][YLEN-1:0]            resp_data,
   output logic                                 resp_id
);
   localparam int SW = $clog2(XLEN);
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_ROT2 = 1'b1;

   logic [0:0]                state_r;
   logic                      pointer_r;
   logic                      grant_s;
   logic                      accept_s;
   logic                      rot_req_s;
   logic                      rot_accept_s;
   logic [XLEN-1:0][YLEN-1:0] sh_data_s;
   logic [XLEN-1:0][YLEN-1:0] sh_result_s;
   logic [XLEN-1:0][YLEN-1:0] resp_next_s;
   logic [SW-1:0]             sh_shamt_s;
   logic                      sh_dir_s;
   logic                      sh_arith_s;

`ifdef SHIFTER_ARB_ROTATE_EN
   logic [XLEN-1:0][YLEN-1:0] rot_data_r;
   logic [XLEN-1:0][YLEN-1:0] rot_pass1_r;
   logic [XLEN-1:0][YLEN-1:0] rot_pass2_s;
   logic [SW-1:0]             rot_shamt_r;
   logic                      rot_dir_r;
   logic                      rot_id_r;

   assign rot_req_s = req_rotate[grant_s];
`else
   logic unused_rotate_s;

   assign unused_rotate_s = ^req_rotate;
   assign rot_req_s       = 1'b0;
`endif

   assign grant_s      = req_valid[pointer_r] ? pointer_r : ~pointer_r;
   assign accept_s     = (state_r == ST_IDLE) && (!resp_valid || resp_ready) && (req_valid != 2'b00);
   assign rot_accept_s = accept_s && rot_req_s;

   // One-hot accept toward the granted requester.
   always_comb begin
      if (accept_s) begin
         req_ready = grant_s ? 2'b10 : 2'b01;
      end else begin
         req_ready = 2'b00;
      end
   end

`ifdef SHIFTER_ARB_ROTATE_EN
   // In ROT2 the shifter runs the opposite-direction pass on the latched operand.
   always_comb begin
      if (state_r == ST_ROT2) begin
         sh_data_s  = rot_data_r;
         sh_shamt_s = {SW{1'b0}} - rot_shamt_r;
         sh_dir_s   = ~rot_dir_r;
         sh_arith_s = 1'b0;
      end else begin
         sh_data_s  = req_data[grant_s];
         sh_shamt_s = req_shamt[grant_s];
         sh_dir_s   = req_left_or_right[grant_s];
         sh_arith_s = req_arith[grant_s] & ~rot_req_s;
      end
   end

   // shamt of zero makes the second pass a full-width pass-through, so it is masked.
   always_comb begin
      if (rot_shamt_r == {SW{1'b0}}) begin
         rot_pass2_s = {(XLEN*YLEN){1'b0}};
      end else begin
         rot_pass2_s = sh_result_s;
      end
      if (state_r == ST_ROT2) begin
         resp_next_s = rot_pass2_s | rot_pass1_r;
      end else begin
         resp_next_s = sh_result_s;
      end
   end

   // Capture the operand and first-pass result of an accepted rotate.
   always_ff @(posedge clock) begin
      if (reset) begin
         rot_data_r  <= {(XLEN*YLEN){1'b0}};
         rot_pass1_r <= {(XLEN*YLEN){1'b0}};
         rot_shamt_r <= {SW{1'b0}};
         rot_dir_r   <= 1'b0;
         rot_id_r    <= 1'b0;
      end else if (rot_accept_s) begin
         rot_data_r  <= req_data[grant_s];
         rot_pass1_r <= sh_result_s;
         rot_shamt_r <= req_shamt[grant_s];
         rot_dir_r   <= req_left_or_right[grant_s];
         rot_id_r    <= grant_s;
      end
   end
`else
   // The shifter always follows the granted request.
   always_comb begin
      sh_data_s   = req_data[grant_s];
      sh_shamt_s  = req_shamt[grant_s];
      sh_dir_s    = req_left_or_right[grant_s];
      sh_arith_s  = req_arith[grant_s] & ~rot_req_s;
      resp_next_s = sh_result_s;
   end
`endif

   full_barrel_shifter #(
      .XLEN (XLEN),
      .YLEN (YLEN)
   ) u_shifter (
      .data                   (sh_data_s),
      .shamt                  (sh_shamt_s),
      .left_or_right_shift    (sh_dir_s),
      .arithmetic_right_shift (sh_arith_s),
      .result                 (sh_result_s)
   );

   // Control FSM, round-robin pointer and the one-entry response register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         pointer_r  <= 1'b0;
         resp_valid <= 1'b0;
         resp_data  <= {(XLEN*YLEN){1'b0}};
         resp_id    <= 1'b0;
      end else begin
         if (accept_s) begin
            pointer_r <= ~grant_s;
         end
         case (state_r)
            ST_IDLE: begin
               if (rot_accept_s) begin
                  state_r    <= ST_ROT2;
                  resp_valid <= 1'b0;
               end else if (accept_s) begin
                  resp_valid <= 1'b1;
                  resp_data  <= resp_next_s;
                  resp_id    <= grant_s;
               end else if (resp_ready) begin
                  resp_valid <= 1'b0;
               end
            end
            ST_ROT2: begin
               state_r <= ST_IDLE;
`ifdef SHIFTER_ARB_ROTATE_EN
               resp_valid <= 1'b1;
               resp_data  <= resp_next_s;
               resp_id    <= rot_id_r;
`endif
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end
endmodule
